// File: rtl/uart_tx_fifo_reader.sv
// uart_tx_fifo_reader: UART transmitter that pops words straight from a TX FIFO head.
module uart_tx_fifo_reader #(
    parameter int DBIT = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            fifo_empty,
    input  logic [DBIT-1:0] fifo_r_data,
    output logic            fifo_rd,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done_tick
);
    localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t state, state_next;
    logic [SW-1:0] s, s_next;
    logic [NW-1:0] n, n_next;
    logic [DBIT-1:0] b, b_next;
    logic tx_next;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= IDLE;
            s <= '0;
            n <= '0;
            b <= '0;
            tx <= 1'b1;
        end else begin
            state <= state_next;
            s <= s_next;
            n <= n_next;
            b <= b_next;
            tx <= tx_next;
        end
    always_comb begin
        state_next = state;
        s_next = s;
        n_next = n;
        b_next = b;
        fifo_rd = 1'b0;
        tx_done_tick = 1'b0;
        case (state)
            IDLE:
                if (!fifo_empty && !reset) begin
                    fifo_rd = 1'b1;
                    b_next = fifo_r_data;
                    s_next = '0;
                    state_next = START;
                end
            START:
                if (s_tick) begin
                    if (s == SW'(15)) begin
                        state_next = DATA;
                        s_next = '0;
                        n_next = '0;
                    end else
                        s_next = s + 1'b1;
                end
            DATA:
                if (s_tick) begin
                    if (s == SW'(15)) begin
                        s_next = '0;
                        b_next = b >> 1;
                        if (n == NW'(DBIT - 1))
                            state_next = STOP;
                        else
                            n_next = n + 1'b1;
                    end else
                        s_next = s + 1'b1;
                end
            STOP:
                if (s_tick) begin
                    if (s == SW'(SB_TICK - 1)) begin
                        state_next = IDLE;
                        tx_done_tick = 1'b1;
                    end else
                        s_next = s + 1'b1;
                end
        endcase
        // line level follows the state being entered so tx lines up with state
        tx_next = (state_next == START) ? 1'b0 : (state_next == DATA) ? b_next[0] : 1'b1;
    end
    assign tx_busy = state != IDLE;
endmodule

// File: doc/uart_tx_fifo_reader.md
UART_TX_FIFO_READER -- requirements
Module: uart_tx_fifo_reader

Interface
REQ-001 Parameter DBIT, default 8, number of data bits per frame.
REQ-002 Parameter SB_TICK, default 16, stop-bit length in oversampling ticks (16 = 1 stop bit, 24 = 1.5, 32 = 2).
REQ-003 clk  input  1  system clock, all registers on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 s_tick  input  1  one-clk pulse at 16x baud rate.
REQ-006 fifo_empty  input  1  TX FIFO empty flag.
REQ-007 fifo_r_data  input  DBIT  TX FIFO head word, valid without a read strobe while fifo_empty=0.
REQ-008 fifo_rd  output  1  one-clk pop strobe to TX FIFO.
REQ-009 tx  output  1  serial line, idle high.
REQ-010 tx_busy  output  1  high whenever state is not IDLE.
REQ-011 tx_done_tick  output  1  one-clk pulse at end of stop bit.

Function
REQ-012 FSM states: IDLE, START, DATA, STOP; state, tick counter s (4 bits min, wide enough for SB_TICK-1), bit counter n, shift register b (DBIT), and tx all registered.
REQ-013 fifo_rd = (state==IDLE) & ~fifo_empty, combinational; no other condition asserts it.
REQ-014 On the fifo_rd edge: b <= fifo_r_data, s <= 0, state <= START; pop and latch occur in the same cycle.
REQ-015 tx is registered: 1 in IDLE/STOP, 0 in START, b[0] in DATA; first start-bit level appears the cycle after fifo_rd.
REQ-016 s, n, and state advance only on cycles with s_tick=1; without s_tick, all hold.
REQ-017 START: on s_tick with s==15 -> DATA, s<=0, n<=0; else on s_tick s<=s+1.
REQ-018 DATA: on s_tick with s==15 -> b shifts right one bit (LSB first), s<=0; if n==DBIT-1 -> STOP, else n<=n+1.
REQ-019 STOP: on s_tick with s==SB_TICK-1 -> IDLE, tx_done_tick=1 for that one cycle.
REQ-020 Frame length: exactly 16*(1+DBIT)+SB_TICK s_tick pulses from first start-bit tick to return to IDLE (160 for 8N1).
REQ-021 Back-to-back: if fifo_empty=0 in the first IDLE cycle after STOP, fifo_rd asserts in that cycle; gap between stop bit end and next start bit = 1 clk (no extra idle ticks).
REQ-022 fifo_empty rising mid-frame has no effect on the current frame.
REQ-023 fifo_r_data changes after the pop do not affect the frame (b is the only source).
REQ-024 s_tick coincident with the fifo_rd cycle is not counted toward START.

Reset
REQ-025 On reset=1, immediately: state=IDLE, s=0, n=0, b=0, tx=1, tx_busy=0, tx_done_tick=0; fifo_rd=0 while reset held.
REQ-026 Reset mid-frame aborts the frame; tx returns high asynchronously; the popped word is discarded and not re-read.
REQ-027 After reset deassertion, the first fifo_rd occurs on the first clk edge with fifo_empty=0.

Verification
REQ-028 Single word 0xA5, DBIT=8, SB_TICK=16, s_tick every 4 clk -> one fifo_rd pulse; tx = 0,1,0,1,0,0,1,0,1,1, each level 16 ticks; one tx_done_tick; tx_busy high 160 ticks.
REQ-029 FIFO holds 0x00, 0xFF -> two fifo_rd pulses; stop bit of word 1 followed after 1 clk by start bit of word 2; serial stream 0,00000000,1 then 0,11111111,1.
REQ-030 fifo_empty=1 permanently -> tx=1, fifo_rd=0, tx_busy=0 for 1000 clk.
REQ-031 Reset asserted during DATA bit 3 of 0x3C -> tx=1 same cycle; state IDLE; after release with FIFO empty, no fifo_rd, no tx_done_tick.
REQ-032 s_tick held low for 50 clk in mid START -> tx stays 0, s frozen; frame completes normally once ticks resume, total still 160 ticks.
REQ-033 SB_TICK=32 with 0x81 -> stop bit lasts 32 ticks; tx_done_tick after 176 ticks.
